// File: rtl/stream_burst_rr_arbiter.sv
// Burst-granular round-robin arbiter sharing one ready/valid sink among NumInp streams.
// Payload is passed through combinationally; only the grant state is registered.

module stream_burst_rr_lane #(
    parameter int NumInp   = 4,
    parameter int IdxWidth = 2,
    parameter int Lane     = 0
) (
    input  logic                rst_i,
    input  logic                locked,
    input  logic [IdxWidth-1:0] lock_idx,
    input  logic [IdxWidth-1:0] rr_idx,
    input  logic [NumInp-1:0]   valid,
    input  logic                oup_ready_i,
    output logic                idle_win,
    output logic                sel,
    output logic                ready
);

    // Distance of requester k from the current round-robin head, wrapping.
    function automatic int rr_dist(input int k, input int r);
        return (k >= r) ? (k - r) : (k + NumInp - r);
    endfunction

    int my_dist;

    always_comb begin
        my_dist  = rr_dist(Lane, int'(rr_idx));
        idle_win = valid[Lane];
        for (int j = 0; j < NumInp; j++) begin
            if (j != Lane && valid[j] && rr_dist(j, int'(rr_idx)) < my_dist) begin
                idle_win = 1'b0;
            end
        end
    end

    assign sel   = locked ? (lock_idx == IdxWidth'(Lane)) : idle_win;
    assign ready = !rst_i && sel && oup_ready_i;

endmodule

module stream_burst_rr_arbiter #(
    parameter int NumInp    = 4,
    parameter int DataWidth = 8,
    parameter int MaxBurst  = 4,
    parameter int IdxWidth  = $clog2(NumInp)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic [NumInp-1:0][DataWidth-1:0]  inp_data_i,
    input  logic [NumInp-1:0]                 inp_valid_i,
    input  logic [NumInp-1:0]                 inp_last_i,
    output logic [NumInp-1:0]                 inp_ready_o,
    output logic [DataWidth-1:0]              oup_data_o,
    output logic                              oup_valid_o,
    output logic                              oup_last_o,
    output logic [IdxWidth-1:0]               oup_idx_o,
    input  logic                              oup_ready_i
);

    localparam int CntWidth = $clog2(MaxBurst + 1);
    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;
    localparam logic [CntWidth:0] MaxBeats = (CntWidth + 1)'(MaxBurst);

    typedef struct packed {
        logic                 valid;
        logic                 last;
        logic [IdxWidth-1:0]  idx;
        logic [DataWidth-1:0] data;
    } oup_t;

    logic [0:0]          fsm_q;
    logic [IdxWidth-1:0] rr_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic [CntWidth-1:0] beat_cnt_q;

    logic                locked;
    logic [NumInp-1:0]   idle_win;
    logic [NumInp-1:0]   sel_oh;
    logic [IdxWidth-1:0] sel_idx;
    logic                sel_valid;
    logic [CntWidth:0]   beat_nxt;
    logic                end_beat;
    logic                hs;
    oup_t                oup;

    assign locked = (fsm_q == StLocked);

    for (genvar g = 0; g < NumInp; g++) begin : g_lane
        stream_burst_rr_lane #(
            .NumInp   (NumInp),
            .IdxWidth (IdxWidth),
            .Lane     (g)
        ) u_lane (
            .rst_i       (rst_i),
            .locked      (locked),
            .lock_idx    (lock_idx_q),
            .rr_idx      (rr_q),
            .valid       (inp_valid_i),
            .oup_ready_i (oup_ready_i),
            .idle_win    (idle_win[g]),
            .sel         (sel_oh[g]),
            .ready       (inp_ready_o[g])
        );
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NumInp; i++) begin
            if (sel_oh[i]) sel_idx = IdxWidth'(i);
        end
    end

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
        return (idx == IdxWidth'(NumInp - 1)) ? '0 : idx + IdxWidth'(1);
    endfunction

    // When locked, sel_oh is the lock one-hot, so this is valid[lock_idx_q].
    assign sel_valid = |(sel_oh & inp_valid_i);
    assign beat_nxt  = {1'b0, beat_cnt_q} + (CntWidth + 1)'(1);
    assign end_beat  = inp_last_i[sel_idx] || (beat_nxt == MaxBeats);
    assign hs        = sel_valid && oup_ready_i;

    always_comb begin
        oup = '0;
        if (!rst_i) begin
            oup.valid = sel_valid;
            oup.last  = sel_valid && end_beat;
            oup.idx   = sel_idx;
            oup.data  = inp_data_i[sel_idx];
        end
    end

    assign oup_valid_o = oup.valid;
    assign oup_last_o  = oup.last;
    assign oup_idx_o   = oup.idx;
    assign oup_data_o  = oup.data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q      <= StIdle;
            rr_q       <= '0;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
        end else if (flush_i) begin
            fsm_q      <= StIdle;
            beat_cnt_q <= '0;
        end else begin
            case (fsm_q)
                StIdle: begin
                    if (hs && end_beat) begin
                        rr_q <= next_idx(sel_idx);
                    end else if (hs) begin
                        fsm_q      <= StLocked;
                        lock_idx_q <= sel_idx;
                        beat_cnt_q <= CntWidth'(1);
                    end else if (sel_valid) begin
                        // Stalled offer: hold the grant so valid/data stay stable.
                        fsm_q      <= StLocked;
                        lock_idx_q <= sel_idx;
                        beat_cnt_q <= '0;
                    end
                end
                StLocked: begin
                    if (hs && end_beat) begin
                        fsm_q      <= StIdle;
                        rr_q       <= next_idx(lock_idx_q);
                        beat_cnt_q <= '0;
                    end else if (hs) begin
                        beat_cnt_q <= beat_nxt[CntWidth-1:0];
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_burst_rr_arbiter.sv
// Scoreboard bench for stream_burst_rr_arbiter: directed scenarios plus a random drain.
// Stimulus pushes expected beats; a negedge monitor pops and compares on every sink handshake.

module tb_stream_burst_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } src_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [N-1:0][DW-1:0]  inp_data;
    logic [N-1:0]          inp_valid;
    logic [N-1:0]          inp_last;
    logic [N-1:0]          inp_ready;
    logic [DW-1:0]         oup_data;
    logic                  oup_valid;
    logic                  oup_last;
    logic [IW-1:0]         oup_idx;
    logic                  oup_ready;

    src_t          drv_q[N][$];
    logic [DW-1:0] rnd_q[N][$];
    beat_t         exp_q[$];
    logic [N-1:0]  hold;
    bit            rnd_mode;
    int            checks;
    int            errors;
    int            burst_cnt;
    logic [IW-1:0] burst_idx;
    beat_t         mon_e;
    logic [DW-1:0] mon_d;

    stream_burst_rr_arbiter #(
        .NumInp    (N),
        .DataWidth (DW),
        .MaxBurst  (MB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .inp_data_i  (inp_data),
        .inp_valid_i (inp_valid),
        .inp_last_i  (inp_last),
        .inp_ready_o (inp_ready),
        .oup_data_o  (oup_data),
        .oup_valid_o (oup_valid),
        .oup_last_o  (oup_last),
        .oup_idx_o   (oup_idx),
        .oup_ready_i (oup_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (drv_q[i].size() > 0 && !hold[i]) begin
                inp_valid[i] = 1'b1;
                inp_data[i]  = drv_q[i][0].data;
                inp_last[i]  = drv_q[i][0].last;
            end else begin
                inp_valid[i] = 1'b0;
                inp_data[i]  = '0;
                inp_last[i]  = 1'b0;
            end
        end
    endtask

    // Sample accepted beats before the edge, pop them after it, re-present fronts.
    task automatic tick();
        logic [N-1:0] acc;
        #1;
        acc = inp_valid & inp_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(drv_q[i].pop_front());
        end
        drive();
    endtask

    function automatic bit pending(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (mask[i] && drv_q[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic run_until_empty(input logic [N-1:0] mask, input int budget);
        int n = 0;
        while (pending(mask) && n < budget) begin
            tick();
            n++;
        end
        if (pending(mask)) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: requesters still pending after %0d cycles", budget);
        end
    endtask

    task automatic push_exp(input int idx, input int data, input bit last);
        beat_t b;
        b.idx  = IW'(idx);
        b.data = DW'(data);
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic push_src(input int i, input int data, input bit last);
        src_t s;
        s.data = DW'(data);
        s.last = last;
        drv_q[i].push_back(s);
    endtask

    // Monitor: every sink handshake is checked against the scoreboard and burst rules.
    always @(negedge clk) begin
        if (!rst && oup_valid && oup_ready) begin
            if (burst_cnt > 0) chk("burst_lock_idx", 32'(oup_idx), 32'(burst_idx));
            burst_idx = oup_idx;
            burst_cnt++;
            if (burst_cnt == MB) chk("burst_cap_last", 32'(oup_last), 32'd1);
            if (oup_last) burst_cnt = 0;
            if (!rnd_mode) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_idx", 32'(oup_idx), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_idx", 32'(oup_idx), 32'(mon_e.idx));
                    chk("beat_data", 32'(oup_data), 32'(mon_e.data));
                    chk("beat_last", 32'(oup_last), 32'(mon_e.last));
                end
            end else begin
                if (rnd_q[oup_idx].size() == 0) begin
                    chk("rnd_extra_beat_idx", 32'(oup_idx), 32'hFFFF_FFFF);
                end else begin
                    mon_d = rnd_q[oup_idx].pop_front();
                    chk("rnd_order_data", 32'(oup_data), 32'(mon_d));
                end
            end
        end
        if (flush) burst_cnt = 0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        checks    = 0;
        errors    = 0;
        burst_cnt = 0;
        burst_idx = '0;
        rnd_mode  = 1'b0;
        rst       = 1'b1;
        flush     = 1'b0;
        oup_ready = 1'b1;
        hold      = '0;

        // Reset with every requester valid, then six last-beats in rr order.
        push_src(0, 8'h10, 1'b1); push_src(0, 8'h14, 1'b1);
        push_src(1, 8'h11, 1'b1); push_src(1, 8'h15, 1'b1);
        push_src(2, 8'h12, 1'b1);
        push_src(3, 8'h13, 1'b1);
        push_exp(0, 8'h10, 1'b1); push_exp(1, 8'h11, 1'b1);
        push_exp(2, 8'h12, 1'b1); push_exp(3, 8'h13, 1'b1);
        push_exp(0, 8'h14, 1'b1); push_exp(1, 8'h15, 1'b1);
        drive();
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("rst_inp_ready", 32'(inp_ready), 32'd0);
            chk("rst_oup_valid", 32'(oup_valid), 32'd0);
            chk("rst_oup_last", 32'(oup_last), 32'd0);
            chk("rst_oup_idx", 32'(oup_idx), 32'd0);
            chk("rst_oup_data", 32'(oup_data), 32'd0);
            tick();
        end
        rst = 1'b0;
        drive();
        #1;
        chk("first_grant_idx", 32'(oup_idx), 32'd0);
        chk("first_grant_valid", 32'(oup_valid), 32'd1);
        run_until_empty('1, 20);
        chk("rr_drain", 32'(exp_q.size()), 32'd0);

        // Burst cap: idx 2 six beats (last on 6th), idx 3 waiting; rr head is 2.
        for (int k = 0; k < 6; k++) push_src(2, 8'h20 + k, k == 5);
        push_src(3, 8'h30, 1'b1);
        push_exp(2, 8'h20, 1'b0); push_exp(2, 8'h21, 1'b0);
        push_exp(2, 8'h22, 1'b0); push_exp(2, 8'h23, 1'b1);
        push_exp(3, 8'h30, 1'b1);
        push_exp(2, 8'h24, 1'b0); push_exp(2, 8'h25, 1'b1);
        drive();
        run_until_empty('1, 30);
        chk("cap_drain", 32'(exp_q.size()), 32'd0);

        // Stall stability: idx 1 offered while the sink stalls; idx 0 joins in cycle 2.
        oup_ready = 1'b0;
        hold      = 4'b0001;
        push_src(1, 8'hA5, 1'b1);
        push_src(0, 8'h05, 1'b1);
        push_exp(1, 8'hA5, 1'b1);
        push_exp(0, 8'h05, 1'b1);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) hold = '0;
            drive();
            #1;
            chk("stall_idx", 32'(oup_idx), 32'd1);
            chk("stall_data", 32'(oup_data), 32'hA5);
            chk("stall_valid", 32'(oup_valid), 32'd1);
            chk("stall_inp_ready", 32'(inp_ready), 32'd0);
            tick();
        end
        oup_ready = 1'b1;
        drive();
        run_until_empty('1, 20);
        chk("stall_drain", 32'(exp_q.size()), 32'd0);

        // Bubble: idx 0 locks (rr head 1, idx 1 held), then drops valid for 2 cycles.
        hold = 4'b0010;
        push_src(0, 8'h40, 1'b0); push_src(0, 8'h41, 1'b0); push_src(0, 8'h42, 1'b1);
        push_src(1, 8'h50, 1'b1);
        push_exp(0, 8'h40, 1'b0); push_exp(0, 8'h41, 1'b0); push_exp(0, 8'h42, 1'b1);
        drive();
        #1;
        chk("bubble_grant_idx", 32'(oup_idx), 32'd0);
        tick();
        hold = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            drive();
            #1;
            chk("bubble_oup_valid", 32'(oup_valid), 32'd0);
            chk("bubble_ready1", 32'(inp_ready[1]), 32'd0);
            tick();
        end
        hold = 4'b0010;
        drive();
        run_until_empty(4'b0001, 20);
        chk("bubble_drain", 32'(exp_q.size()), 32'd0);

        // Flush while locked on idx 2 (rr head stays 1); idx 1 must win right after.
        hold = 4'b1010;
        push_src(2, 8'h60, 1'b0); push_src(2, 8'h61, 1'b0);
        push_src(2, 8'h62, 1'b0); push_src(2, 8'h63, 1'b1);
        push_src(3, 8'h70, 1'b1);
        push_exp(2, 8'h60, 1'b0); push_exp(2, 8'h61, 1'b0); push_exp(1, 8'h50, 1'b1);
        push_exp(2, 8'h62, 1'b0); push_exp(2, 8'h63, 1'b1); push_exp(3, 8'h70, 1'b1);
        drive();
        #1;
        chk("flush_lock_idx", 32'(oup_idx), 32'd2);
        tick();
        flush = 1'b1;
        drive();
        #1;
        chk("flush_cycle_idx", 32'(oup_idx), 32'd2);
        chk("flush_cycle_valid", 32'(oup_valid), 32'd1);
        tick();
        flush = 1'b0;
        hold  = 4'b0100;
        drive();
        #1;
        chk("post_flush_idx", 32'(oup_idx), 32'd1);
        chk("post_flush_valid", 32'(oup_valid), 32'd1);
        tick();
        hold = '0;
        drive();
        run_until_empty('1, 30);
        chk("flush_drain", 32'(exp_q.size()), 32'd0);

        // Random drain: 1000 beats, 10% bubble rate per requester, 10% sink stall rate.
        rnd_mode = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            int i;
            logic [DW-1:0] d;
            i = $urandom_range(0, N - 1);
            d = DW'($urandom);
            push_src(i, d, $urandom_range(0, 3) == 0);
            rnd_q[i].push_back(d);
        end
        begin
            int n = 0;
            while (pending('1) && n < 20000) begin
                for (int i = 0; i < N; i++) hold[i] = ($urandom_range(0, 9) == 0);
                oup_ready = ($urandom_range(0, 9) != 0);
                drive();
                tick();
                n++;
            end
        end
        if (pending('1)) begin
            checks++;
            errors++;
            $display("FAIL rnd_timeout: requesters still pending");
        end
        for (int i = 0; i < N; i++) chk("rnd_no_loss", 32'(rnd_q[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
